// File: rtl/trig_level_gen.sv
// trig_level_gen: level trigger with optional hysteresis and glitch filter.
// Optional feature macro: TRIG_HYST_EN (hysteresis band via hyst input).
module trig_level_gen #(
  parameter int DATA_W = 8,
  parameter int FILT_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              ad_valid,
  input  logic [DATA_W-1:0] trig_level,
  input  logic [DATA_W-1:0] hyst,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              trig_edge,
  output logic              trigger,
  output logic              trig_pulse,
  output logic [CNT_W-1:0]  edge_cnt
);

  typedef enum logic [1:0] {
    LOW,
    RISE_PEND,
    HIGH,
    FALL_PEND
  } state_t;

  state_t state;

  logic [FILT_W-1:0] fcnt;
  logic [FILT_W-1:0] flen;
  logic [FILT_W:0]   fnext;
  logic              done;
  logic [DATA_W-1:0] hi_th;
  logic [DATA_W-1:0] lo_th;
  logic              above;
  logic              below;

`ifdef TRIG_HYST_EN
  logic [DATA_W:0] hi_sum;

  assign hi_sum = {1'b0, trig_level} + {1'b0, hyst};
  assign hi_th  = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
  assign lo_th  = (trig_level > hyst) ? trig_level - hyst : '0;
`else
  logic unused_hyst;

  assign unused_hyst = ^hyst;
  assign hi_th       = trig_level;
  assign lo_th       = trig_level;
`endif

  assign above = ad_data >= hi_th;
  assign below = ad_data < lo_th;

  // A zero filter length behaves like one.
  assign flen  = (filt_len == '0) ? FILT_W'(1) : filt_len;
  assign fnext = {1'b0, fcnt} + (FILT_W + 1)'(1);
  assign done  = fnext >= {1'b0, flen};

  // Qualification FSM with registered level, pulse and edge counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= LOW;
      fcnt       <= '0;
      trigger    <= 1'b0;
      trig_pulse <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      trig_pulse <= 1'b0;
      if (ad_valid) begin
        unique case (state)
          LOW, RISE_PEND: begin
            if (!above) begin
              state <= LOW;
              fcnt  <= '0;
            end else if (done) begin
              state   <= HIGH;
              fcnt    <= '0;
              trigger <= 1'b1;
              if (trig_edge) begin
                trig_pulse <= 1'b1;
                edge_cnt   <= edge_cnt + CNT_W'(1);
              end
            end else begin
              state <= RISE_PEND;
              fcnt  <= fnext[FILT_W-1:0];
            end
          end
          HIGH, FALL_PEND: begin
            if (!below) begin
              state <= HIGH;
              fcnt  <= '0;
            end else if (done) begin
              state   <= LOW;
              fcnt    <= '0;
              trigger <= 1'b0;
              if (!trig_edge) begin
                trig_pulse <= 1'b1;
                edge_cnt   <= edge_cnt + CNT_W'(1);
              end
            end else begin
              state <= FALL_PEND;
              fcnt  <= fnext[FILT_W-1:0];
            end
          end
          default: begin
            state <= LOW;
            fcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trig_level_gen.sv
// tb_trig_level_gen: scoreboard bench for trig_level_gen.
// Random and directed stimulus against a run-length reference model.
module tb_trig_level_gen;

  localparam int CW = 8;

`ifdef TRIG_HYST_EN
  localparam int RISE_AT = 8'h90;
  localparam int FALL_LO = 8'h70;
`else
  localparam int RISE_AT = 8'h80;
  localparam int FALL_LO = 8'h80;
`endif

  logic          sys_clk;
  logic          sys_rst;
  logic [7:0]    ad_data;
  logic          ad_valid;
  logic [7:0]    trig_level;
  logic [7:0]    hyst;
  logic [3:0]    filt_len;
  logic          trig_edge;
  logic          trigger;
  logic          trig_pulse;
  logic [CW-1:0] edge_cnt;

  trig_level_gen #(
    .DATA_W(8),
    .FILT_W(4),
    .CNT_W (CW)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .ad_data   (ad_data),
    .ad_valid  (ad_valid),
    .trig_level(trig_level),
    .hyst      (hyst),
    .filt_len  (filt_len),
    .trig_edge (trig_edge),
    .trigger   (trigger),
    .trig_pulse(trig_pulse),
    .edge_cnt  (edge_cnt)
  );

  typedef struct packed {
    logic          t;
    logic          p;
    logic [CW-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // reference model state
  int   m_trig = 0;
  int   m_run  = 0;
  int   m_cnt  = 0;
  int   m_pls  = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic model(input logic rst, input logic v, input int d);
    int hi, lo, fl;
    bit q;
    if (rst) begin
      m_trig = 0;
      m_run  = 0;
      m_cnt  = 0;
      m_pls  = 0;
      return;
    end
    m_pls = 0;
    if (!v) return;
`ifdef TRIG_HYST_EN
    hi = int'(trig_level) + int'(hyst);
    if (hi > 255) hi = 255;
    lo = int'(trig_level) - int'(hyst);
    if (lo < 0) lo = 0;
`else
    hi = int'(trig_level);
    lo = int'(trig_level);
`endif
    fl = (filt_len == 0) ? 1 : int'(filt_len);
    q  = m_trig ? (d < lo) : (d >= hi);
    if (!q) begin
      m_run = 0;
      return;
    end
    m_run++;
    if (m_run >= fl) begin
      m_trig = 1 - m_trig;
      m_run  = 0;
      if (m_trig == int'(trig_edge)) begin
        m_pls = 1;
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [7:0] d);
    exp_t e;
    sys_rst  = rst;
    ad_valid = v;
    ad_data  = d;
    model(rst, v, int'(d));
    e.t = m_trig[0];
    e.p = m_pls[0];
    e.c = CW'(m_cnt);
    exp_q.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  // monitor: pops one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: got no expectation at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if ({trigger, trig_pulse, edge_cnt} !== {e.t, e.p, e.c}) begin
          n_err++;
          $display("FAIL sb t=%0t: got trig=%b pls=%b cnt=%0h want trig=%b pls=%b cnt=%0h",
                   $time, trigger, trig_pulse, edge_cnt, e.t, e.p, e.c);
        end
      end
    end
  end

  initial begin
    sys_rst    = 1'b1;
    ad_valid   = 1'b0;
    ad_data    = 8'h00;
    trig_level = 8'h80;
    hyst       = 8'h00;
    filt_len   = 4'd1;
    trig_edge  = 1'b1;
    #2;
    step(1, 0, 8'h00);
    step(1, 1, 8'hFF);
    check("rst_trig", int'(trigger), 0);
    check("rst_cnt", int'(edge_cnt), 0);

    // reset mid-qualification
    filt_len = 4'd4;
    repeat (3) step(0, 1, 8'hE0);
    step(1, 1, 8'hE0);
    check("midq_trig", int'(trigger), 0);
    check("midq_pls", int'(trig_pulse), 0);
    check("midq_cnt", int'(edge_cnt), 0);
    repeat (3) step(0, 1, 8'hE0);
    check("midq_3", int'(trigger), 0);
    step(0, 1, 8'hE0);
    check("midq_4", int'(trigger), 1);

    // square wave, filt 1
    step(1, 0, 8'h00);
    filt_len = 4'd1;
    for (int p = 0; p < 10; p++) begin
      repeat (8) step(0, 1, 8'h20);
      repeat (8) step(0, 1, 8'hE0);
    end
    check("sq_cnt", int'(edge_cnt), 10);

    // glitch rejection
    step(1, 0, 8'h00);
    filt_len = 4'd3;
    for (int g = 0; g < 4; g++) begin
      repeat (4) step(0, 1, 8'h10);
      repeat (2) step(0, 1, 8'hFF);
    end
    step(0, 1, 8'h10);
    check("gl_trig", int'(trigger), 0);
    check("gl_cnt", int'(edge_cnt), 0);
    repeat (2) step(0, 1, 8'hFF);
    check("gl_2", int'(trigger), 0);
    step(0, 1, 8'hFF);
    check("gl_3", int'(trigger), 1);
    check("gl_cnt3", int'(edge_cnt), 1);

    // hysteresis ramp
    step(1, 0, 8'h00);
    filt_len = 4'd1;
    hyst     = 8'h10;
    for (int d = 8'h70; d <= 8'h95; d++) begin
      step(0, 1, 8'(d));
      if (d == RISE_AT - 1 || d == RISE_AT)
        check("hy_up", int'(trigger), int'(d >= RISE_AT));
    end
    for (int d = 8'h94; d >= 8'h6F; d--) begin
      step(0, 1, 8'(d));
      if (d == FALL_LO || d == FALL_LO - 1)
        check("hy_dn", int'(trigger), int'(d >= FALL_LO));
    end

    // saturation with gaps
    step(1, 0, 8'h00);
    trig_level = 8'hF8;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] pat [4];
      pat = '{8'hFE, 8'hFF, 8'hF0, 8'h10};
      step(0, i[0] == 1'b0, pat[(i / 2) % 4]);
    end

    // counter wrap
    step(1, 0, 8'h00);
    trig_level = 8'h80;
    hyst       = 8'h00;
    trig_edge  = 1'b1;
    repeat (300) begin
      step(0, 1, 8'h00);
      step(0, 1, 8'hFF);
    end
    check("wrap_cnt", int'(edge_cnt), 300 % (1 << CW));

    // randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        trig_level = 8'($urandom);
        hyst       = 8'($urandom_range(0, 40));
        filt_len   = 4'($urandom_range(0, 5));
        trig_edge  = 1'($urandom);
      end
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trig_level_gen.md
# trig_level_gen

Sample-domain trigger conditioner that turns the ADC sample stream into the clean square-wave `trigger` consumed by the frequency-measurement stage. It compares each valid sample against a programmable level, with optional hysteresis and a consecutive-sample glitch filter. It also emits a one-cycle pulse and a wrapping event count on the selected edge. It sits between the ADC capture interface and the frequency counter, in the `sys_clk` domain.

## Interface
- `DATA_W`, 8: sample and threshold width, unsigned.
- `FILT_W`, 4: width of the filter-length input.
- `CNT_W`, 16: width of the edge counter.

- `sys_clk`  in  1: the single clock; all logic is on its rising edge.
- `sys_rst`  in  1: synchronous, active-high reset.
- `ad_data`  in  DATA_W: ADC sample, unsigned.
- `ad_valid`  in  1: `ad_data` is valid this cycle.
- `trig_level`  in  DATA_W: threshold level.
- `hyst`  in  DATA_W: hysteresis half-band. Used only when `TRIG_HYST_EN` is defined.
- `filt_len`  in  FILT_W: number of consecutive qualifying samples needed to change state. A value of 0 is treated as 1.
- `trig_edge`  in  1: selects the counted edge. 1 = rising, 0 = falling.
- `trigger`  out  1: conditioned level output; this drives the frequency-counter `trigger`.
- `trig_pulse`  out  1: one-cycle pulse on the selected transition of `trigger`.
- `edge_cnt`  out  CNT_W: count of selected transitions; wraps.

## Operation
- Thresholds are recomputed on every valid sample from the current inputs:
  - `hi_th = min(trig_level + hyst, 2^DATA_W - 1)`, computed at DATA_W+1 bits and saturated.
  - `lo_th = max(trig_level - hyst, 0)`, saturated.
- Sample classification:
  - above: `ad_data >= hi_th`.
  - below: `ad_data < lo_th`.
  - Otherwise the sample is in-band and neutral.
- States are LOW, RISE_PEND, HIGH and FALL_PEND. A filter counter `fcnt` is FILT_W bits. `flen = max(filt_len, 1)`.
- Only cycles with `ad_valid`=1 advance the state machine. When `ad_valid`=0, state, `fcnt` and outputs are held, and `trig_pulse` is 0.
- LOW:
  - Above with `flen`=1: go to HIGH.
  - Above with `flen`>1: go to RISE_PEND with `fcnt`=1.
  - Otherwise: stay in LOW.
- RISE_PEND:
  - Above: `fcnt`+1. When `fcnt`+1 == `flen`, go to HIGH and clear `fcnt`.
  - Below or in-band: go back to LOW and clear `fcnt`.
- HIGH and FALL_PEND mirror LOW and RISE_PEND, using "below" in place of "above".
- `trigger` = 1 in HIGH and FALL_PEND, 0 in LOW and RISE_PEND. The output is registered.
- `trig_pulse` = 1 for exactly the cycle in which `trigger` makes the transition selected by `trig_edge`. `edge_cnt` increments in that same cycle and wraps from all-ones to 0.
- Changes to `trig_level`, `hyst`, `filt_len` or `trig_edge` take effect on the next valid sample. They do not reset the state or `fcnt`.
- If `filt_len` is lowered below the current `fcnt` while in a PEND state, the next qualifying sample completes the transition (comparison is `fcnt`+1 >= `flen`).

## Timing
- Reset values: state LOW, `fcnt`=0, `trigger`=0, `trig_pulse`=0, `edge_cnt`=0.
- Reset has priority over every other event, including a valid sample in the same cycle.
- Reset can be asserted at any time. Any pending qualification is discarded and no pulse is emitted.
- Latency: when the qualifying sample is presented with `ad_valid` at edge k, `trigger`, `trig_pulse` and `edge_cnt` update at edge k and are visible in cycle k+1.
- With `flen`=N and samples valid every cycle, `trigger` changes N cycles after the first qualifying sample is presented.
- After reset the block starts in LOW. An input that is already above the threshold produces a rising transition after `flen` valid samples. That transition is counted when `trig_edge`=1.
- `trig_pulse` is never high in two consecutive cycles. The minimum spacing is `flen` valid samples.

## Configuration
- `TRIG_HYST_EN` defined: `hyst` is used and the two thresholds are computed as described above.
- `TRIG_HYST_EN` undefined: `hyst` is ignored.
  - `hi_th = lo_th = trig_level`.
  - Above and below are then complementary and there is no in-band region.
  - The saturation adders are not built.

## Test plan
- Reset mid-qualification: `flen`=4, three above samples, then `sys_rst` asserted together with the fourth above sample. Required: state LOW, `trigger`=0, `trig_pulse`=0, `edge_cnt`=0; afterwards four fresh above samples are needed for a transition.
- Square input, valid every cycle: `trig_level`=0x80, `filt_len`=1, `trig_edge`=1, `ad_data` alternates 0x20 and 0xE0 with 8-sample halves for 10 periods. Required: `trigger` lags the input by 1 cycle, `trig_pulse` occurs 10 times, `edge_cnt`=10.
- Glitch rejection: `filt_len`=3, a low signal with 2-sample spikes to 0xFF. Required: `trigger` stays 0 and `edge_cnt` stays 0. A 3-sample spike gives one rising transition, visible 1 cycle after the third sample.
- Hysteresis (`TRIG_HYST_EN` defined): `trig_level`=0x80, `hyst`=0x10, a ramp 0x70→0x95→0x75→0x6F. Required: rise at 0x90, no fall until 0x6F; with the macro undefined, rise at 0x80 and fall at 0x7F.
- Saturation and gaps: `trig_level`=0xF8, `hyst`=0x10 gives `hi_th`=0xFF, so only 0xFF qualifies as above. With `ad_valid` toggled 1/0 throughout, state changes only on valid cycles. With `edge_cnt` preloaded near wrap, 0xFFFF+1 reads 0x0000.
